// File: rtl/encap_hdr_gen.sv
// encap_hdr_gen
//   Prepends a 42-byte outer header (Ethernet + 802.1Q + IPv4 + GRE) to an
//   inner frame and realigns the payload by two bytes onto a 64-bit bus.
//   With encap_en=0 the frame is forwarded unchanged with one cycle latency.
//
// Ports
//   clk, rst_n                 core clock, asynchronous active-low reset
//   mac_da, mac_sa             outer MAC addresses
//   vlan                       802.1Q TCI
//   ip_sa, ip_da               outer IPv4 addresses
//   gre_header                 GRE flags/version/protocol word
//   identification             IPv4 ID base (per-packet counter is added)
//   ttl, dscp_ecn              IPv4 fields
//   encap_en                   1=encapsulate, 0=pass-through
//   in_*                       inner frame stream (valid/ready, byte 0 in [63:56])
//   out_*                      outer frame stream, same encoding
//   err_nosop                  one-cycle pulse when a non-sop beat is dropped in IDLE
`timescale 1ns/1ps
module encap_hdr_gen #(
    parameter logic [7:0]  GRE_PROTO_IP = 8'h2F,
    parameter logic [15:0] IP_FLAGS     = 16'h4000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [47:0] mac_da,
    input  logic [47:0] mac_sa,
    input  logic [15:0] vlan,
    input  logic [31:0] ip_sa,
    input  logic [31:0] ip_da,
    input  logic [31:0] gre_header,
    input  logic [15:0] identification,
    input  logic [7:0]  ttl,
    input  logic [7:0]  dscp_ecn,
    input  logic        encap_en,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_data,
    input  logic        in_sop,
    input  logic        in_eop,
    input  logic [2:0]  in_mod,
    input  logic [15:0] in_len,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_data,
    output logic        out_sop,
    output logic        out_eop,
    output logic [2:0]  out_mod,
    output logic        err_nosop
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_FIRST,
        S_BODY,
        S_TAIL,
        S_PASS
    } state_t;

    state_t      state_q, state_d;

    // Per-packet configuration snapshot
    logic [47:0] da_q, sa_q;
    logic [15:0] vlan_q;
    logic [31:0] ip_sa_q, ip_da_q, gre_q;
    logic [15:0] id_q, tot_len_q;
    logic [7:0]  ttl_q, dscp_q;

    logic [15:0] id_cnt_q, id_cnt_d;
    logic [15:0] csum_q;
    logic [2:0]  hdr_cnt_q, hdr_cnt_d;
    logic [15:0] carry_q, carry_d;
    logic [2:0]  tail_mod_q, tail_mod_d;

    logic [63:0] out_data_q, out_data_d;
    logic        out_valid_q, out_valid_d;
    logic        out_sop_q, out_sop_d;
    logic        out_eop_q, out_eop_d;
    logic [2:0]  out_mod_q, out_mod_d;
    logic        err_q, err_d;

    logic        latch;
    logic        adv;
    logic [3:0]  n_eop;
    logic [335:0] hdr_vec;
    logic [63:0] hdr_beat;

    // IPv4 header checksum over the latched fields (csum word taken as zero)
    logic [31:0] csum_sum, csum_f1, csum_f2;

    always_comb begin
        csum_sum = {16'h0, 8'h45, dscp_q} + {16'h0, tot_len_q} + {16'h0, id_q}
                 + {16'h0, IP_FLAGS} + {16'h0, ttl_q, GRE_PROTO_IP}
                 + {16'h0, ip_sa_q[31:16]} + {16'h0, ip_sa_q[15:0]}
                 + {16'h0, ip_da_q[31:16]} + {16'h0, ip_da_q[15:0]};
        csum_f1  = {16'h0, csum_sum[15:0]} + {16'h0, csum_sum[31:16]};
        csum_f2  = {16'h0, csum_f1[15:0]} + {16'h0, csum_f1[31:16]};
    end

    assign hdr_vec = {da_q, sa_q, 16'h8100, vlan_q, 16'h0800,
                      8'h45, dscp_q, tot_len_q, id_q, IP_FLAGS,
                      ttl_q, GRE_PROTO_IP, csum_q, ip_sa_q, ip_da_q, gre_q};

    always_comb begin
        hdr_beat = '0;
        case (hdr_cnt_q)
            3'd0:    hdr_beat = hdr_vec[335:272];
            3'd1:    hdr_beat = hdr_vec[271:208];
            3'd2:    hdr_beat = hdr_vec[207:144];
            3'd3:    hdr_beat = hdr_vec[143:80];
            3'd4:    hdr_beat = hdr_vec[79:16];
            default: hdr_beat = '0;
        endcase
    end

    assign adv   = out_ready | ~out_valid_q;
    assign n_eop = (in_mod == 3'd0) ? 4'd8 : {1'b0, in_mod};

    always_comb begin
        state_d     = state_q;
        id_cnt_d    = id_cnt_q;
        hdr_cnt_d   = hdr_cnt_q;
        carry_d     = carry_q;
        tail_mod_d  = tail_mod_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_sop_d   = out_sop_q;
        out_eop_d   = out_eop_q;
        out_mod_d   = out_mod_q;
        err_d       = 1'b0;
        latch       = 1'b0;
        in_ready    = 1'b0;

        case (state_q)
            S_IDLE: begin
                // The sop beat is left on the bus; HDR/PASS consumes it later.
                in_ready = ~in_sop;
                if (adv) out_valid_d = 1'b0;
                if (in_valid) begin
                    if (in_sop) begin
                        latch     = 1'b1;
                        hdr_cnt_d = '0;
                        state_d   = encap_en ? S_HDR : S_PASS;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end

            S_HDR: begin
                if (adv) begin
                    out_valid_d = 1'b1;
                    out_data_d  = hdr_beat;
                    out_sop_d   = (hdr_cnt_q == 3'd0);
                    out_eop_d   = 1'b0;
                    out_mod_d   = '0;
                    hdr_cnt_d   = hdr_cnt_q + 3'd1;
                    if (hdr_cnt_q == 3'd4) state_d = S_FIRST;
                end
            end

            S_FIRST, S_BODY: begin
                in_ready = adv;
                if (adv) begin
                    out_valid_d = in_valid;
                    if (in_valid) begin
                        out_data_d = {(state_q == S_FIRST) ? hdr_vec[15:0] : carry_q,
                                      in_data[63:16]};
                        carry_d    = in_data[15:0];
                        out_sop_d  = 1'b0;
                        out_eop_d  = 1'b0;
                        out_mod_d  = '0;
                        state_d    = S_BODY;
                        if (in_eop) begin
                            // Up to 6 bytes fit beside the 2 carried bytes;
                            // 7 or 8 spill into an extra TAIL beat.
                            if (n_eop <= 4'd6) begin
                                out_eop_d = 1'b1;
                                out_mod_d = 3'(n_eop + 4'd2);
                                id_cnt_d  = id_cnt_q + 16'd1;
                                state_d   = S_IDLE;
                            end else begin
                                tail_mod_d = 3'(n_eop - 4'd6);
                                state_d    = S_TAIL;
                            end
                        end
                    end
                end
            end

            S_TAIL: begin
                if (adv) begin
                    out_valid_d = 1'b1;
                    out_data_d  = {carry_q, 48'h0};
                    out_sop_d   = 1'b0;
                    out_eop_d   = 1'b1;
                    out_mod_d   = tail_mod_q;
                    id_cnt_d    = id_cnt_q + 16'd1;
                    state_d     = S_IDLE;
                end
            end

            S_PASS: begin
                in_ready = adv;
                if (adv) begin
                    out_valid_d = in_valid;
                    if (in_valid) begin
                        out_data_d = in_data;
                        out_sop_d  = in_sop;
                        out_eop_d  = in_eop;
                        out_mod_d  = in_mod;
                        if (in_eop) state_d = S_IDLE;
                    end
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            da_q        <= '0;
            sa_q        <= '0;
            vlan_q      <= '0;
            ip_sa_q     <= '0;
            ip_da_q     <= '0;
            gre_q       <= '0;
            id_q        <= '0;
            tot_len_q   <= '0;
            ttl_q       <= '0;
            dscp_q      <= '0;
            id_cnt_q    <= '0;
            csum_q      <= '0;
            hdr_cnt_q   <= '0;
            carry_q     <= '0;
            tail_mod_q  <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_sop_q   <= 1'b0;
            out_eop_q   <= 1'b0;
            out_mod_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            id_cnt_q    <= id_cnt_d;
            hdr_cnt_q   <= hdr_cnt_d;
            carry_q     <= carry_d;
            tail_mod_q  <= tail_mod_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_sop_q   <= out_sop_d;
            out_eop_q   <= out_eop_d;
            out_mod_q   <= out_mod_d;
            err_q       <= err_d;
            // Follows the latched fields by one cycle; settled long before beat 3.
            csum_q      <= ~csum_f2[15:0];
            if (latch) begin
                da_q      <= mac_da;
                sa_q      <= mac_sa;
                vlan_q    <= vlan;
                ip_sa_q   <= ip_sa;
                ip_da_q   <= ip_da;
                gre_q     <= gre_header;
                id_q      <= identification + id_cnt_q;
                tot_len_q <= in_len + 16'd24;
                ttl_q     <= ttl;
                dscp_q    <= dscp_ecn;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sop   = out_sop_q;
    assign out_eop   = out_eop_q;
    assign out_mod   = out_mod_q;
    assign err_nosop = err_q;

endmodule

// File: tb/tb_encap_hdr_gen.sv
// Directed bench for encap_hdr_gen: header/checksum contents, eop realignment
// cases, back-to-back ID increment, output backpressure, pass-through,
// non-sop drop and mid-packet reset.
`timescale 1ns/1ps
module tb_encap_hdr_gen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [47:0] mac_da, mac_sa;
    logic [15:0] vlan;
    logic [31:0] ip_sa, ip_da, gre_header;
    logic [15:0] identification;
    logic [7:0]  ttl, dscp_ecn;
    logic        encap_en;
    logic        in_valid, in_ready;
    logic [63:0] in_data;
    logic        in_sop, in_eop;
    logic [2:0]  in_mod;
    logic [15:0] in_len;
    logic        out_valid, out_ready;
    logic [63:0] out_data;
    logic        out_sop, out_eop;
    logic [2:0]  out_mod;
    logic        err_nosop;

    int n_chk = 0;
    int n_err = 0;

    logic [63:0] q_data[$];
    logic        q_sop[$];
    logic        q_eop[$];
    logic [2:0]  q_mod[$];
    int          eop_seen = 0;
    int          err_cnt  = 0;
    logic        rand_ready = 1'b0;
    logic [7:0]  exp_hdr [0:41];

    always #5 clk = ~clk;

    encap_hdr_gen #(.GRE_PROTO_IP(8'h2F), .IP_FLAGS(16'h4000)) dut (
        .clk(clk), .rst_n(rst_n),
        .mac_da(mac_da), .mac_sa(mac_sa), .vlan(vlan),
        .ip_sa(ip_sa), .ip_da(ip_da), .gre_header(gre_header),
        .identification(identification), .ttl(ttl), .dscp_ecn(dscp_ecn),
        .encap_en(encap_en),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_sop(in_sop), .in_eop(in_eop), .in_mod(in_mod), .in_len(in_len),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_sop(out_sop), .out_eop(out_eop), .out_mod(out_mod),
        .err_nosop(err_nosop)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Downstream ready: always 1, or random when backpressure is enabled
    always @(negedge clk) out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;

    // Output monitor: a beat visible here with ready high transfers at the next posedge
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (out_valid && out_ready) begin
                q_data.push_back(out_data);
                q_sop.push_back(out_sop);
                q_eop.push_back(out_eop);
                q_mod.push_back(out_mod);
                if (out_eop) eop_seen++;
            end
            if (err_nosop) err_cnt++;
        end
    end

    initial begin
        #400us;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", n_err + 1, n_chk + 1);
        $fatal(1);
    end

    function automatic logic [63:0] make_beat(input int nbytes, input logic [7:0] seed, input int b);
        logic [63:0] d;
        d = '0;
        for (int k = 0; k < 8; k++)
            if (b * 8 + k < nbytes) d[63 - 8 * k -: 8] = 8'(seed + 8'(b * 8 + k));
        return d;
    endfunction

    task automatic clear_obs();
        q_data.delete(); q_sop.delete(); q_eop.delete(); q_mod.delete();
        eop_seen = 0;
    endtask

    task automatic send_frame(input int nbytes, input logic [7:0] seed, input int abort_after);
        int nbeats, waited, accepted;
        nbeats   = (nbytes + 7) / 8;
        accepted = 0;
        for (int b = 0; b < nbeats; b++) begin
            if (abort_after >= 0 && accepted == abort_after) return;
            @(negedge clk);
            in_valid = 1'b1;
            in_sop   = (b == 0);
            in_eop   = (b == nbeats - 1);
            in_mod   = (b == nbeats - 1) ? 3'(nbytes % 8) : 3'd0;
            in_len   = 16'(nbytes);
            in_data  = make_beat(nbytes, seed, b);
            waited   = 0;
            forever begin
                #1;
                if (in_ready) begin
                    @(posedge clk);
                    break;
                end
                @(negedge clk);
                waited++;
                if (waited > 500) begin
                    check_eq("drv_timeout", 64'(waited), 64'd0);
                    in_valid = 1'b0;
                    return;
                end
            end
            accepted++;
        end
    endtask

    task automatic idle_inputs();
        @(negedge clk);
        in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; in_mod = '0; in_data = '0;
    endtask

    task automatic wait_eops(input int n);
        int cyc;
        cyc = 0;
        while (eop_seen < n && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        #3;
        check_eq("eop_wait", 64'(eop_seen >= n), 64'd1);
    endtask

    // Hand-written outer header for the fixed test configuration
    task automatic set_hdr(input logic [15:0] tl, input logic [15:0] id, input logic [15:0] cs);
        logic [7:0] h [0:41];
        h = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01,
              8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h02,
              8'h81, 8'h00, 8'h00, 8'h64, 8'h08, 8'h00,
              8'h45, 8'h00, tl[15:8], tl[7:0], id[15:8], id[7:0],
              8'h40, 8'h00, 8'h40, 8'h2F, cs[15:8], cs[7:0],
              8'h0A, 8'h00, 8'h00, 8'h01, 8'h0A, 8'h00, 8'h00, 8'h02,
              8'h00, 8'h00, 8'h65, 8'h58};
        exp_hdr = h;
    endtask

    task automatic check_encap(input string tag, inout int idx, input int nbytes,
                               input logic [7:0] seed, input logic [15:0] tl,
                               input logic [15:0] id, input logic [15:0] cs,
                               input int exp_beats, input int exp_lastmod);
        logic [7:0]  ob[$];
        logic [63:0] d;
        int beats, sop_bad, hdr_bad, pay_bad, lastmod, nvalid;
        beats = 0; sop_bad = 0; hdr_bad = 0; pay_bad = 0; lastmod = -1;
        set_hdr(tl, id, cs);
        while (idx < q_data.size()) begin
            d      = q_data[idx];
            nvalid = q_eop[idx] ? ((q_mod[idx] == 3'd0) ? 8 : int'(q_mod[idx])) : 8;
            if (q_sop[idx] != (beats == 0)) sop_bad++;
            for (int k = 0; k < nvalid; k++) ob.push_back(d[63 - 8 * k -: 8]);
            beats++;
            idx++;
            if (q_eop[idx - 1]) begin
                lastmod = int'(q_mod[idx - 1]);
                break;
            end
        end
        for (int i = 0; i < 42; i++)
            if (i >= ob.size() || ob[i] !== exp_hdr[i]) hdr_bad++;
        for (int j = 0; j < nbytes; j++)
            if (42 + j >= ob.size() || ob[42 + j] !== 8'(seed + 8'(j))) pay_bad++;
        check_eq({tag, "_beats"},   64'(beats),     64'(exp_beats));
        check_eq({tag, "_lastmod"}, 64'(lastmod),   64'(exp_lastmod));
        check_eq({tag, "_bytes"},   64'(ob.size()), 64'(42 + nbytes));
        check_eq({tag, "_sop"},     64'(sop_bad),   64'd0);
        check_eq({tag, "_hdrbad"},  64'(hdr_bad),   64'd0);
        check_eq({tag, "_paybad"},  64'(pay_bad),   64'd0);
        if (ob.size() >= 42) begin
            check_eq({tag, "_totlen"}, {48'h0, ob[20], ob[21]}, {48'h0, tl});
            check_eq({tag, "_id"},     {48'h0, ob[22], ob[23]}, {48'h0, id});
            check_eq({tag, "_csum"},   {48'h0, ob[28], ob[29]}, {48'h0, cs});
            check_eq({tag, "_gre"},    {48'h0, ob[40], ob[41]}, 64'h6558);
        end
    endtask

    initial begin
        int idx, pbad, nb;
        rst_n = 1'b0;
        mac_da = 48'h020000000001; mac_sa = 48'h020000000002;
        vlan = 16'h0064; ip_sa = 32'h0A000001; ip_da = 32'h0A000002;
        gre_header = 32'h00006558; identification = 16'h1234;
        ttl = 8'h40; dscp_ecn = 8'h00; encap_en = 1'b1;
        in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; in_mod = '0;
        in_data = '0; in_len = '0; out_ready = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_out_data",  out_data,       64'd0);
        check_eq("rst_out_flags", {61'h0, out_sop, out_eop, err_nosop}, 64'd0);
        check_eq("rst_out_mod",   64'(out_mod),   64'd0);
        check_eq("rst_in_ready",  64'(in_ready),  64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 60-byte frame followed back-to-back by an identical one
        clear_obs();
        send_frame(60, 8'h10, -1);
        send_frame(60, 8'h10, -1);
        idle_inputs();
        wait_eops(2);
        idx = 0;
        check_encap("p60a", idx, 60, 8'h10, 16'h0054, 16'h1234, 16'h1445, 13, 6);
        check_encap("p60b", idx, 60, 8'h10, 16'h0054, 16'h1235, 16'h1444, 13, 6);

        // 63-byte frame: eop carries 7 bytes -> TAIL beat with 1 byte
        clear_obs();
        send_frame(63, 8'h50, -1);
        idle_inputs();
        wait_eops(1);
        idx = 0;
        check_encap("p63", idx, 63, 8'h50, 16'h0057, 16'h1236, 16'h1440, 14, 1);

        // 64-byte frame: eop carries 8 bytes -> TAIL beat with 2 bytes
        clear_obs();
        send_frame(64, 8'h80, -1);
        idle_inputs();
        wait_eops(1);
        idx = 0;
        check_encap("p64", idx, 64, 8'h80, 16'h0058, 16'h1237, 16'h143E, 14, 2);

        // Random downstream backpressure
        clear_obs();
        rand_ready = 1'b1;
        send_frame(60, 8'hC3, -1);
        idle_inputs();
        wait_eops(1);
        rand_ready = 1'b0;
        repeat (2) @(negedge clk);
        idx = 0;
        check_encap("bp60", idx, 60, 8'hC3, 16'h0054, 16'h1238, 16'h1441, 13, 6);

        // Pass-through: 20-byte frame forwarded unchanged
        clear_obs();
        encap_en = 1'b0;
        send_frame(20, 8'hA0, -1);
        idle_inputs();
        wait_eops(1);
        encap_en = 1'b1;
        pbad = 0;
        nb = q_data.size();
        for (int b = 0; b < nb && b < 3; b++) begin
            if (q_data[b] !== make_beat(20, 8'hA0, b)) pbad++;
            if (q_sop[b] !== (b == 0)) pbad++;
            if (q_eop[b] !== (b == 2)) pbad++;
        end
        check_eq("pass_beats",   64'(nb), 64'd3);
        check_eq("pass_databad", 64'(pbad), 64'd0);
        if (nb == 3) check_eq("pass_mod", 64'(q_mod[2]), 64'd4);

        // Non-sop beat while idle: dropped, one err_nosop pulse
        clear_obs();
        err_cnt = 0;
        @(negedge clk);
        in_valid = 1'b1; in_sop = 1'b0; in_eop = 1'b0; in_data = 64'hDEADBEEFCAFEF00D;
        #1;
        check_eq("nosop_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        idle_inputs();
        repeat (4) @(negedge clk);
        #3;
        check_eq("nosop_err_pulses", 64'(err_cnt), 64'd1);
        check_eq("nosop_no_output",  64'(q_data.size()), 64'd0);

        // Reset asserted mid-packet, in BODY
        clear_obs();
        send_frame(60, 8'h30, 3);
        #2;
        rst_n = 1'b0;
        in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
        #1;
        check_eq("midrst_out_valid", 64'(out_valid), 64'd0);
        check_eq("midrst_out_data",  out_data,       64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        clear_obs();
        send_frame(60, 8'h40, -1);
        idle_inputs();
        wait_eops(1);
        idx = 0;
        check_encap("post_rst", idx, 60, 8'h40, 16'h0054, 16'h1234, 16'h1445, 13, 6);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
